// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// the rotation-index helper used by the round-robin picker.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_SEND  = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_t;

  // Wraps base+offset back into [0, n) without a modulo operator; offset < n.
  function automatic int unsigned rr_wrap(input int unsigned base,
                                          input int unsigned offset,
                                          input int unsigned n);
    int unsigned sum;
    sum = base + offset;
    return (sum >= n) ? (sum - n) : sum;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first asserted request at
// rotation positions ptr, ptr+1, ... (modulo NUM_REQ).
module uart_tx_arbiter_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       valid
);

  localparam int IDX_W = $clog2(NUM_REQ);

  int unsigned w_idx;

  // Scanning from the far end lets the closest-to-ptr hit overwrite the rest.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    w_idx  = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = rr_wrap(int'(ptr), k, NUM_REQ);
      if (req[w_idx]) begin
        winner = IDX_W'(w_idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// Optional SEND-state watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int WORD_LENGHT    = 8,
  parameter int FREQUENCY      = 50000000,
  parameter int BAUDRATE       = 9600,
  parameter int TIMEOUT_CYCLES = 4 * FREQUENCY / BAUDRATE
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*WORD_LENGHT-1:0] data_in,
  output logic [NUM_REQ-1:0]             ack,
  input  logic                           tx_ready,
  output logic [WORD_LENGHT-1:0]         tx_data,
  output logic                           send,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           busy,
  output logic                           timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ must be at least 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_t              r_state;
  arb_state_t              w_state_nxt;
  logic [IDX_W-1:0]        r_ptr;
  logic [IDX_W-1:0]        r_grant_id;
  logic [IDX_W-1:0]        w_ptr_nxt;
  logic [WORD_LENGHT-1:0]  r_tx_data;
  logic [NUM_REQ-1:0]      r_ack;
  logic [IDX_W-1:0]        w_pick;
  logic                    w_pick_vld;
  logic                    w_grant;
  logic                    w_accept;
  logic                    w_timeout;

  uart_tx_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req    (req),
    .ptr    (r_ptr),
    .winner (w_pick),
    .valid  (w_pick_vld)
  );

`ifdef UART_ARB_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDOG_W-1:0] r_wdog;
  logic              r_timeout_err;
  logic              w_wdog_hit;

  assign w_wdog_hit = (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1)) && tx_ready;

  // Watchdog: cleared on the grant that enters SEND, saturates at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout;
      if (w_grant) begin
        r_wdog <= '0;
      end else if ((r_state == ARB_SEND) && (r_wdog != WDOG_W'(TIMEOUT_CYCLES))) begin
        r_wdog <= r_wdog + 1'b1;
      end
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_accept    = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (tx_ready && w_pick_vld) begin
          w_grant     = 1'b1;
          w_state_nxt = ARB_SEND;
        end
      end
      ARB_SEND: begin
        if (!tx_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = ARB_DRAIN;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (w_wdog_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = ARB_IDLE;
        end
`endif
      end
      ARB_DRAIN: begin
        if (tx_ready) begin
          w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  assign w_ptr_nxt = (r_grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : (r_grant_id + 1'b1);

  // Grant latch, rotation pointer and the registered ack pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr      <= '0;
      r_grant_id <= '0;
      r_tx_data  <= '0;
      r_ack      <= '0;
    end else begin
      r_ack <= w_accept ? (NUM_REQ'(1) << r_grant_id) : '0;
      if (w_grant) begin
        r_grant_id <= w_pick;
        r_tx_data  <= data_in[w_pick*WORD_LENGHT +: WORD_LENGHT];
      end
      if (w_accept || w_timeout) begin
        r_ptr <= w_ptr_nxt;
      end
    end
  end

  assign send     = (r_state == ARB_SEND);
  assign busy     = (r_state != ARB_IDLE);
  assign ack      = r_ack;
  assign tx_data  = r_tx_data;
  assign grant_id = r_grant_id;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter; the bench plays the UART
// handshake (tx_ready) by hand. Timeout scenario runs when UART_ARB_TIMEOUT_EN is set.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WL      = 8;
  localparam int TMO     = 16;

  logic              clk;
  logic              rst;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ*WL-1:0] data_in;
  logic [NUM_REQ-1:0] ack;
  logic              tx_ready;
  logic [WL-1:0]     tx_data;
  logic              send;
  logic [1:0]        grant_id;
  logic              busy;
  logic              timeout_err;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .WORD_LENGHT    (WL),
    .FREQUENCY      (50000000),
    .BAUDRATE       (9600),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .data_in     (data_in),
    .ack         (ack),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .send        (send),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "bench time limit");
  end

  task automatic apply_reset();
    rst = 1'b1; req = '0; tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Waits (bounded) for send at a falling edge; ok=0 if it never shows up.
  task automatic wait_send(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (send) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  // UART side: take the byte (tx_ready low), report ack, finish the frame.
  task automatic uart_complete(output logic [NUM_REQ-1:0] ack_seen);
    tx_ready = 1'b0;
    @(negedge clk);
    ack_seen = ack;
    repeat (2) @(negedge clk);
    tx_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; tx_ready = 1'b1; data_in = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({send, busy, ack, timeout_err, tx_data, grant_id} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: send=%b busy=%b ack=%b terr=%b tx_data=%h gid=%0d expected all zero",
               send, busy, ack, timeout_err, tx_data, grant_id);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy=%b expected 0", busy); end
  endtask

  task automatic test_single();
    apply_reset();
    data_in = {8'h00, 8'h00, 8'h00, 8'hA5};
    req = 4'b0001;
    @(negedge clk);
    checks++;
    if (send !== 1'b1 || tx_data !== 8'hA5 || grant_id !== 2'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: send=%b tx_data=%h gid=%0d busy=%b expected 1 a5 0 1", send, tx_data, grant_id, busy);
    end
    tx_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (ack !== 4'b0001 || send !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_ack: ack=%b send=%b busy=%b expected 0001 0 1", ack, send, busy);
    end
    req = '0;
    @(negedge clk);
    checks++;
    if (ack !== 4'b0000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_drain: ack=%b busy=%b expected 0000 1", ack, busy);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tx_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_idle: busy=%b tx_data=%h expected 0 a5", busy, tx_data);
    end
  endtask

  task automatic test_all_requesting();
    int exp_id;
    bit ok;
    logic [NUM_REQ-1:0] a;
    logic [WL-1:0] exp_d;
    apply_reset();
    data_in = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_id = i % NUM_REQ;
      exp_d  = WL'((exp_id + 1) * 17);
      wait_send(ok);
      checks++;
      if (!ok || grant_id !== 2'(exp_id) || tx_data !== exp_d) begin
        errors++;
        $display("FAIL rr_grant_%0d: seen=%b gid=%0d data=%h expected gid=%0d data=%h", i, ok, grant_id, tx_data, exp_id, exp_d);
      end
      uart_complete(a);
      checks++;
      if (a !== 4'(1 << exp_id)) begin
        errors++;
        $display("FAIL rr_ack_%0d: ack=%b expected %b", i, a, 4'(1 << exp_id));
      end
    end
    req = '0;
  endtask

  task automatic test_drop_mid_transfer();
    bit ok;
    logic [NUM_REQ-1:0] a;
    apply_reset();
    data_in = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    req = 4'b1100;
    wait_send(ok);
    checks++;
    if (!ok || grant_id !== 2'd2 || tx_data !== 8'hC2) begin
      errors++;
      $display("FAIL drop_grant: seen=%b gid=%0d data=%h expected gid=2 data=c2", ok, grant_id, tx_data);
    end
    req = 4'b1000;
    uart_complete(a);
    checks++;
    if (a !== 4'b0100) begin errors++; $display("FAIL drop_ack: ack=%b expected 0100", a); end
    wait_send(ok);
    checks++;
    if (!ok || grant_id !== 2'd3 || tx_data !== 8'hD3) begin
      errors++;
      $display("FAIL drop_next: seen=%b gid=%0d data=%h expected gid=3 data=d3", ok, grant_id, tx_data);
    end
    req = '0;
    uart_complete(a);
    checks++;
    if (a !== 4'b1000) begin errors++; $display("FAIL drop_next_ack: ack=%b expected 1000", a); end
  endtask

  task automatic test_reset_mid_transfer();
    bit ok;
    logic [NUM_REQ-1:0] a;
    apply_reset();
    data_in = {8'h04, 8'h03, 8'h02, 8'h01};
    req = 4'b0010;
    wait_send(ok);
    uart_complete(a);
    checks++;
    if (!ok || a !== 4'b0010) begin errors++; $display("FAIL rmt_first: seen=%b ack=%b expected 1 0010", ok, a); end
    req = 4'b0101;
    wait_send(ok);
    checks++;
    if (!ok || grant_id !== 2'd2) begin errors++; $display("FAIL rmt_rotation: seen=%b gid=%0d expected 2", ok, grant_id); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (send !== 1'b0 || busy !== 1'b0 || grant_id !== 2'd0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL rmt_async: send=%b busy=%b gid=%0d data=%h expected 0 0 0 00", send, busy, grant_id, tx_data);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wait_send(ok);
    checks++;
    if (!ok || grant_id !== 2'd0 || tx_data !== 8'h01) begin
      errors++;
      $display("FAIL rmt_restart: seen=%b gid=%0d data=%h expected gid=0 data=01", ok, grant_id, tx_data);
    end
    req = 4'b0100;
    uart_complete(a);
    req = '0;
    checks++;
    if (a !== 4'b0001) begin errors++; $display("FAIL rmt_restart_ack: ack=%b expected 0001", a); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_tx_busy();
    int sends;
    logic [NUM_REQ-1:0] a;
    apply_reset();
    data_in = {8'h00, 8'h00, 8'h00, 8'h5A};
    tx_ready = 1'b0;
    req = 4'b0001;
    sends = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (send || busy) sends++;
    end
    checks++;
    if (sends !== 0) begin errors++; $display("FAIL busy_hold: grant cycles=%0d expected 0", sends); end
    tx_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (send !== 1'b1 || tx_data !== 8'h5A) begin
      errors++;
      $display("FAIL busy_release: send=%b data=%h expected 1 5a", send, tx_data);
    end
    req = '0;
    uart_complete(a);
    checks++;
    if (a !== 4'b0001) begin errors++; $display("FAIL busy_ack: ack=%b expected 0001", a); end
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    bit acked;
    int cnt;
    logic [NUM_REQ-1:0] a;
    apply_reset();
    data_in = {8'h00, 8'h00, 8'h77, 8'h66};
    req = 4'b0011;
    wait_send(ok);
    cnt = 0;
    acked = 1'b0;
    while (send && cnt < 100) begin
      cnt++;
      if (ack != '0) acked = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (!ok || cnt !== TMO || timeout_err !== 1'b1 || acked || ack !== '0) begin
      errors++;
      $display("FAIL timeout_abort: send_cycles=%0d terr=%b acked=%b expected %0d 1 0", cnt, timeout_err, acked, TMO);
    end
    @(negedge clk);
    checks++;
    if (send !== 1'b1 || grant_id !== 2'd1 || tx_data !== 8'h77 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_next: send=%b gid=%0d data=%h terr=%b expected 1 1 77 0", send, grant_id, tx_data, timeout_err);
    end
    req = '0;
    uart_complete(a);
    checks++;
    if (a !== 4'b0010) begin errors++; $display("FAIL timeout_next_ack: ack=%b expected 0010", a); end
  endtask
`endif

  initial begin
    rst = 1'b1; req = '0; tx_ready = 1'b1; data_in = '0;
    test_reset();
    test_single();
    test_all_requesting();
    test_drop_mid_transfer();
    test_reset_mid_transfer();
    test_tx_busy();
`ifdef UART_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
